multi_channel_stable_barrier: RTL and testbench
===============================================

Name: multi_channel_stable_barrier

Overview:
Parametrised successor to the per-bit latching barrier. It carries CHANNELS independent WIDTH-bit words into the clk domain, each through an SYNC_STAGES-deep flop chain. Each word then passes a per-channel stability filter, and the output word is updated only after the synchronised value has held for STABLE_CYCLES consecutive cycles. It sits at every asynchronous multi-bit boundary (config words, status buses, slow sensor codes) where per-bit synchronisation alone could commit a torn word.

Parameters:
CHANNELS, 4, number of independent channels (>=1)
WIDTH, 8, bits per channel (>=1)
SYNC_STAGES, 2, flop stages per bit in the synchroniser chain (>=2)
STABLE_CYCLES, 3, consecutive unchanged cycles required before commit (>=1)
RESET_VALUE, 0, reset value of every channel's chain, shadow and output word (WIDTH bits)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
enable  input  1  global advance; when low, all state holds
in  input  CHANNELS*WIDTH  asynchronous input words; channel c is in[c*WIDTH +: WIDTH]
out  output  CHANNELS*WIDTH  committed, glitch-free words, same packing as in
changed  output  CHANNELS  one-cycle pulse when channel c commits a new value
stable  output  CHANNELS  high while channel c's synchronised value has been unchanged for at least STABLE_CYCLES cycles

Behaviour:
- Reset (rst low, asynchronous): all chain stages, shadow registers p[c] and out = RESET_VALUE; counters = 0; changed = 0; stable = 0. Release is synchronous to clk.
- Synchroniser: each bit has an SYNC_STAGES flop chain, all flops on posedge clk. s[c] is the last-stage word. No logic sits between stages.
- Per channel, on each posedge with enable=1:
  - p[c] <= s[c].
  - If s[c] != p[c], cnt[c] <= 0. Otherwise cnt[c] <= min(cnt[c]+1, STABLE_CYCLES), saturating.
  - cnt width is clog2(STABLE_CYCLES+1).
  - Commit condition: cnt_next == STABLE_CYCLES and s[c] != out[c]. On commit, out[c] <= s[c] and changed[c] <= 1. Otherwise changed[c] <= 0.
- stable[c] is registered and equals (cnt[c] == STABLE_CYCLES).
- Latency: an input change settled before edge 1 reaches s at edge SYNC_STAGES. It is seen by p at edge SYNC_STAGES+1, where cnt resets to 0. out and changed update at edge SYNC_STAGES+1+STABLE_CYCLES. With the defaults this is edge 6.
- Glitch rejection: if s[c] changes again before cnt reaches STABLE_CYCLES, cnt restarts and out[c] is not touched. Intermediate values are never committed.
- A return to the current out value after instability produces no commit and no changed pulse.
- enable=0: chains, p, cnt, out, stable all hold. changed is forced to 0 on the next edge. A pulse in progress lasts exactly one cycle and is never stretched. On re-enable, counting resumes from the held cnt.
- Channels are fully independent. Simultaneous commits on several channels are allowed, and each asserts its own changed bit in the same cycle.
- Saturation: cnt holds at STABLE_CYCLES indefinitely. No wrap, and no repeat pulse while the value stays stable.
- Reset mid-operation: immediately returns all state to reset values. A pending commit is discarded, and a changed pulse in flight is cleared.
- The caller must guarantee the source holds each intended value for at least SYNC_STAGES+STABLE_CYCLES+1 clk cycles.

Test Plan:
- Reset/idle: hold rst low, in=0x00 on all channels, then release -> out=0, changed=0, stable rises on all channels 3 cycles after the first full chain fill, and no changed pulse ever occurs.
- Single commit latency (defaults): ch0 in 0x00->0xA5 just before edge 1 -> out[7:0]=0xA5 and changed[0]=1 exactly after edge 6, changed[0]=0 after edge 7, other channels unaffected.
- Glitch rejection: ch1 in 0x00->0x3C for 2 cycles, then back to 0x00 -> out ch1 stays 0x00, no changed[1] pulse, stable[1] drops and re-asserts.
- Enable stall: ch2 in 0x00->0xFF, deassert enable for 5 cycles starting at edge 3 -> out ch2 commits 5 cycles later than unstalled (edge 11), with one changed[2] pulse.
- Simultaneous channels plus reset mid-flight: ch0=0x11 and ch3=0x22 change together -> both commit on the same edge with changed=4'b1001. Repeat with rst pulsed low at edge 4 -> out stays 0x00 and no pulse is produced.
- Parameter sweep: SYNC_STAGES=3, STABLE_CYCLES=1, CHANNELS=1, WIDTH=1, in 0->1 -> out=1 at edge 5.

Source files
------------

// File: rtl/multi_channel_stable_barrier.sv
// Multi-channel clock-domain barrier. Each WIDTH-bit channel is brought into
// the clk domain through a SYNC_STAGES-deep flop chain. The committed output
// word only moves after the synchronised value has held for STABLE_CYCLES
// consecutive cycles, so a word torn by per-bit synchronisation skew is never
// presented downstream.
module multi_channel_stable_barrier #(
    parameter int                CHANNELS      = 4,
    parameter int                WIDTH         = 8,
    parameter int                SYNC_STAGES   = 2,
    parameter int                STABLE_CYCLES = 3,
    parameter logic [WIDTH-1:0]  RESET_VALUE   = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [CHANNELS*WIDTH-1:0] in,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       changed,
    output logic [CHANNELS-1:0]       stable
);

    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

    // Synchroniser chain, stage 0 samples the asynchronous input.
    logic [CHANNELS*WIDTH-1:0] chain [SYNC_STAGES];
    logic [CHANNELS*WIDTH-1:0] s;

    // Per-channel stability tracking state.
    logic [WIDTH-1:0] p        [CHANNELS];
    logic [CW-1:0]    cnt      [CHANNELS];
    logic [CW-1:0]    cnt_next [CHANNELS];
    logic [WIDTH-1:0] s_word   [CHANNELS];
    logic [CHANNELS-1:0] commit;

    assign s = chain[SYNC_STAGES-1];

    // Advance every synchroniser chain by one stage per enabled edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the chain array is reset explicitly; leaving it unreset
            // would let X propagate into the stability filter after release.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= {CHANNELS{RESET_VALUE}};
            end
        end else if (enable) begin
            chain[0] <= in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    // Next counter value and commit decision for each channel.
    // NOTE: every output of this block gets a default before the loop so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        s_word   = '{default: '0};
        cnt_next = '{default: '0};
        commit   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            s_word[c] = s[c*WIDTH +: WIDTH];
            if (s_word[c] != p[c]) begin
                cnt_next[c] = '0;
            end else if (cnt[c] == CNT_MAX) begin
                cnt_next[c] = CNT_MAX;
            end else begin
                cnt_next[c] = cnt[c] + CW'(1);
            end
            commit[c] = (cnt_next[c] == CNT_MAX) &&
                        (s_word[c] != out[c*WIDTH +: WIDTH]);
        end
    end

    // Shadow, counter, committed word and status flags per channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                p[c]   <= RESET_VALUE;
                cnt[c] <= '0;
            end
            out     <= {CHANNELS{RESET_VALUE}};
            changed <= '0;
            stable  <= '0;
        end else if (enable) begin
            for (int c = 0; c < CHANNELS; c++) begin
                p[c]      <= s_word[c];
                cnt[c]    <= cnt_next[c];
                stable[c] <= (cnt_next[c] == CNT_MAX);
                changed[c] <= commit[c];
                if (commit[c]) begin
                    out[c*WIDTH +: WIDTH] <= s_word[c];
                end
            end
        end else begin
            // A stalled barrier never stretches a pulse.
            changed <= '0;
        end
    end

endmodule

// File: tb/tb_multi_channel_stable_barrier.sv
// Scoreboard bench for multi_channel_stable_barrier: stimulus pushes the
// expected commit (edge, changed mask, full output word) into a queue and an
// independent monitor pops and compares whenever changed is asserted.
module tb_multi_channel_stable_barrier;

    localparam int CH = 4;
    localparam int W  = 8;

    logic              clk    = 1'b0;
    logic              rst    = 1'b0;
    logic              enable = 1'b0;
    logic [CH*W-1:0]   in     = '0;
    logic [CH*W-1:0]   out;
    logic [CH-1:0]     changed;
    logic [CH-1:0]     stable;

    logic              in2 = 1'b0;
    logic              out2;
    logic              changed2;
    logic              stable2;

    typedef struct {
        int unsigned     cyc;
        logic [CH-1:0]   chg;
        logic [CH*W-1:0] val;
    } exp_t;

    exp_t            sbq [$];
    exp_t            e;
    int unsigned     cyc    = 0;
    int unsigned     k;
    int              errors = 0;
    int              checks = 0;
    logic [CH*W-1:0] exp_out = '0;

    multi_channel_stable_barrier dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .in      (in),
        .out     (out),
        .changed (changed),
        .stable  (stable)
    );

    multi_channel_stable_barrier #(
        .CHANNELS      (1),
        .WIDTH         (1),
        .SYNC_STAGES   (3),
        .STABLE_CYCLES (1),
        .RESET_VALUE   (1'b0)
    ) dut_sweep (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .in      (in2),
        .out     (out2),
        .changed (changed2),
        .stable  (stable2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] v);
        in[c*W +: W] = v;
    endtask

    task automatic push(input int unsigned at, input logic [CH-1:0] m, input logic [CH*W-1:0] v);
        exp_t x;
        x.cyc = at;
        x.chg = m;
        x.val = v;
        sbq.push_back(x);
    endtask

    // Monitor: counts edges and checks every changed pulse against the queue.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (changed !== '0) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: changed=0x%0h out=0x%0h required no pulse (cycle %0d)",
                         changed, out, cyc);
            end else begin
                e = sbq.pop_front();
                check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                check("pulse_mask", 64'(changed), 64'(e.chg));
                check("pulse_out", 64'(out), 64'(e.val));
            end
        end
    end

    initial begin
        // Reset and idle.
        rst = 1'b0; enable = 1'b1; in = '0;
        step(3);
        check("reset_out", 64'(out), 64'h0);
        check("reset_changed", 64'(changed), 64'h0);
        check("reset_stable", 64'(stable), 64'h0);
        check("reset_out2", 64'(out2), 64'h0);
        rst = 1'b1;
        step(2);
        check("idle_stable_e2", 64'(stable), 64'h0);
        step(1);
        check("idle_stable_e3", 64'(stable), 64'hF);
        step(5);
        check("idle_out", 64'(out), 64'h0);

        // Single commit latency on channel 0.
        k = cyc;
        set_ch(0, 8'hA5);
        exp_out[7:0] = 8'hA5;
        push(k + 6, 4'b0001, exp_out);
        step(5);
        check("lat_e5_out", 64'(out), 64'h0);
        step(1);
        check("lat_e6_out", 64'(out), 64'(exp_out));
        check("lat_e6_changed", 64'(changed), 64'h1);
        step(1);
        check("lat_e7_changed", 64'(changed), 64'h0);
        check("lat_e7_stable", 64'(stable), 64'hF);
        step(5);

        // Glitch rejection on channel 1.
        k = cyc;
        set_ch(1, 8'h3C);
        step(2);
        set_ch(1, 8'h00);
        step(1);
        check("glitch_stable_e3", 64'(stable[1]), 64'h0);
        step(4);
        check("glitch_stable_e7", 64'(stable[1]), 64'h0);
        step(1);
        check("glitch_stable_e8", 64'(stable[1]), 64'h1);
        check("glitch_out", 64'(out), 64'(exp_out));
        step(5);

        // Enable stall on channel 2.
        k = cyc;
        set_ch(2, 8'hFF);
        exp_out[23:16] = 8'hFF;
        push(k + 11, 4'b0100, exp_out);
        step(2);
        enable = 1'b0;
        step(5);
        enable = 1'b1;
        step(3);
        check("stall_e10_out", 64'(out[23:16]), 64'h0);
        step(1);
        check("stall_e11_out", 64'(out), 64'(exp_out));
        step(5);

        // Simultaneous commits on channels 0 and 3.
        k = cyc;
        set_ch(0, 8'h11);
        set_ch(3, 8'h22);
        exp_out[7:0]   = 8'h11;
        exp_out[31:24] = 8'h22;
        push(k + 6, 4'b1001, exp_out);
        step(6);
        check("simul_changed", 64'(changed), 64'h9);
        step(5);

        // Reset in the middle of a pending commit.
        set_ch(0, 8'h55);
        set_ch(3, 8'h66);
        step(3);
        rst = 1'b0;
        in  = '0;
        step(1);
        check("midrst_out", 64'(out), 64'h0);
        check("midrst_changed", 64'(changed), 64'h0);
        rst = 1'b1;
        exp_out = '0;
        step(12);
        check("midrst_out_after", 64'(out), 64'h0);
        check("midrst_stable_after", 64'(stable), 64'hF);

        // Parameter sweep instance: SYNC_STAGES=3, STABLE_CYCLES=1.
        in2 = 1'b1;
        step(4);
        check("sweep_e4_out", 64'(out2), 64'h0);
        step(1);
        check("sweep_e5_out", 64'(out2), 64'h1);
        check("sweep_e5_changed", 64'(changed2), 64'h1);
        step(1);
        check("sweep_e6_changed", 64'(changed2), 64'h0);

        step(2);
        check("sb_empty", 64'(sbq.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
